fifo_fill_ctrl: RTL and testbench

- Upstream fill stage for the matrix-vector MAC array.
- On a start pulse, reads 9 packed 64-bit words from memory: words 0..7 are matrix A rows, word 8 is vector B.
- Unpacks each word into 8 bytes and writes them, one byte per cycle, into the matching input FIFO (FIFO 0..7 = A, FIFO 8 = B).
- Honours memory waitrequest and per-FIFO wrfull backpressure; signals done when all FIFOs are loaded.

---
 rtl/fifo_fill_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fill_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_fill_ctrl
// Upstream fill stage for the matrix-vector MAC array. On a start pulse it
// reads NUM_ROWS packed words from memory (rows 0..NUM_ROWS-2 = matrix A,
// last row = vector B), unpacks each word LSB byte first and writes one byte
// per cycle into the FIFO matching the row. Memory waitrequest and the
// selected FIFO's wrfull both stall the sequence without losing data.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle fill request (ignored while busy)
//   mem_address/_read   registered word read request, held while waitrequest
//   mem_waitrequest     request not accepted this cycle
//   mem_readdata/valid  read response, only consumed while waiting for it
//   fifo_data           byte shared by every FIFO data input
//   fifo_wrreq          one-hot write strobe, bit r drives FIFO r
//   fifo_wrfull         full flag from each FIFO
//   busy / done         fill in progress / all rows loaded (held until restart)
// -----------------------------------------------------------------------------
module fifo_fill_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 9,
  parameter int WORD_BYTES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic                             mem_read,
  input  logic                             mem_waitrequest,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] mem_readdata,
  input  logic                             mem_readdatavalid,
  output logic [DATA_WIDTH-1:0]            fifo_data,
  output logic [NUM_ROWS-1:0]              fifo_wrreq,
  input  logic [NUM_ROWS-1:0]              fifo_wrfull,
  output logic                             busy,
  output logic                             done
);

  localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_UNPACK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wr_s;

  // State and datapath registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      byte_idx_q <= '0;
      data_q     <= '0;
      mem_read_q <= 1'b0;
      addr_q     <= BASE_ADDR;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      mem_read_q <= mem_read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic plus the combinational FIFO write strobe and data byte.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    mem_read_d = mem_read_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fifo_wrreq = '0;
    fifo_data  = '0;
    wr_s       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // The first read request is registered together with the state
          // change so it is on the bus in the very first REQ cycle.
          state_d    = S_REQ;
          row_d      = '0;
          byte_idx_d = '0;
          mem_read_d = 1'b1;
          addr_d     = BASE_ADDR;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      S_REQ: begin
        if (mem_read_q && !mem_waitrequest) begin
          state_d    = S_WAIT;
          mem_read_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WAIT: begin
        if (mem_readdatavalid) begin
          data_d     = mem_readdata;
          byte_idx_d = '0;
          state_d    = S_UNPACK;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_UNPACK: begin
        fifo_data        = data_q[int'(byte_idx_q) * DATA_WIDTH +: DATA_WIDTH];
        // A full target FIFO simply holds the byte index: no write, no loss.
        wr_s             = !fifo_wrfull[row_q];
        fifo_wrreq[row_q] = wr_s;
        if (wr_s) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d    = S_REQ;
              row_d      = row_q + ROW_W'(1);
              mem_read_d = 1'b1;
              addr_d     = BASE_ADDR + ADDR_WIDTH'(row_q) + ADDR_WIDTH'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_read    = mem_read_q;
  assign mem_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fifo_fill_ctrl. Expected FIFO writes and memory
// addresses are pushed to scoreboards when a fill is started and popped as
// the DUT produces writes / accepted reads. A small memory model answers
// each accepted read one cycle later with word r = bytes {r7..r0}.
// -----------------------------------------------------------------------------
module tb_fifo_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [63:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [7:0]  fifo_data;
  logic [8:0]  fifo_wrreq;
  logic [8:0]  fifo_wrfull;
  logic        busy;
  logic        done;

  int total;
  int bad;
  int ncyc;
  int start_cyc;
  int nacc;
  int wr_total;
  int wait_left;
  int wait_addr;
  int full_left;
  int restart_row;
  int abort_row;
  bit full_mode;
  bit junk;
  bit restarted;
  bit aborted;
  bit acc_pending;
  bit prev_stall;
  logic [31:0] acc_addr;
  logic [31:0] prev_addr;
  logic [15:0] exp_q[$];
  logic [31:0] addr_q[$];

  fifo_fill_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fifo_data         (fifo_data),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrfull       (fifo_wrfull),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mkword(input logic [31:0] r);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'(r * 16 + 32'(k));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst();
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("rst_fifo_data", 64'(fifo_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs 1 later.
  task automatic cyc();
    logic [15:0] e;
    @(negedge clk);
    ncyc++;
    start = 1'b0;
    if (restart_row >= 0 && !restarted && exp_q.size() > 0 &&
        int'(exp_q[0][15:8]) == restart_row) begin
      start     = 1'b1;
      restarted = 1'b1;
    end
    mem_readdatavalid = 1'b0;
    if (acc_pending) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = mkword(acc_addr);
      acc_pending       = 1'b0;
      if (abort_row >= 0 && int'(acc_addr) == abort_row) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end
    end else if (junk) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
    end
    mem_waitrequest = (wait_left > 0) && mem_read && (int'(mem_address) == wait_addr);
    if (mem_waitrequest) wait_left--;
    fifo_wrfull = '0;
    if (full_mode && exp_q.size() > 0 && exp_q[0][15:8] == 8'd8) begin
      fifo_wrfull[7:0] = 8'hFF;
      if (wr_total == 67 && full_left > 0) begin
        fifo_wrfull[8] = 1'b1;
        full_left--;
      end
    end
    #1;
    if (!rst_n) chk_rst();
    chk("wrreq_vs_full", 64'(fifo_wrreq & fifo_wrfull), 64'd0);
    if (fifo_wrreq !== 9'd0) begin
      wr_total++;
      if (exp_q.size() == 0) begin
        chk("spurious_wrreq", 64'(fifo_wrreq), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wrreq", 64'(fifo_wrreq), 64'(9'd1 << e[15:8]));
        chk("fifo_data", 64'(fifo_data), 64'(e[7:0]));
      end
    end
    if (prev_stall) begin
      chk("stall_read", 64'(mem_read), 64'd1);
      chk("stall_addr", 64'(mem_address), 64'(prev_addr));
    end
    prev_stall = mem_read && mem_waitrequest;
    prev_addr  = mem_address;
    if (mem_read && !mem_waitrequest) begin
      nacc++;
      acc_pending = 1'b1;
      acc_addr    = mem_address;
      if (addr_q.size() == 0) chk("extra_read", 64'(mem_read), 64'd0);
      else chk("mem_address", 64'(mem_address), 64'(addr_q.pop_front()));
    end
  endtask

  // Start a fill, run it to done (or abort) and check latency and totals.
  task automatic run_fill(input int exp_lat);
    int lat;
    lat = -1;
    exp_q.delete();
    addr_q.delete();
    for (int r = 0; r < 9; r++) begin
      addr_q.push_back(32'(r));
      for (int k = 0; k < 8; k++) exp_q.push_back({8'(r), 8'(r * 16 + k)});
    end
    nacc      = 0;
    wr_total  = 0;
    restarted = 1'b0;
    aborted   = 1'b0;
    start     = 1'b1;
    start_cyc = ncyc;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (aborted) break;
      if (ncyc == start_cyc + 1) begin
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
      end
      if (done === 1'b1) begin
        lat = ncyc - start_cyc - 1;
        break;
      end
    end
    if (!aborted) begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("writes_left", 64'(exp_q.size()), 64'd0);
      chk("reads_left", 64'(addr_q.size()), 64'd0);
      chk("read_count", 64'(nacc), 64'd9);
    end else begin
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    total = 0; bad = 0; ncyc = 0; nacc = 0; wr_total = 0;
    wait_left = 0; wait_addr = -1; full_left = 0;
    restart_row = -1; abort_row = -1;
    full_mode = 1'b0; junk = 1'b0; restarted = 1'b0; aborted = 1'b0;
    acc_pending = 1'b0; prev_stall = 1'b0;
    acc_addr = '0; prev_addr = '0;
    rst_n = 1'b0; start = 1'b0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    fifo_wrfull = '0;

    // Reset, then 20 idle cycles with no start.
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_rst();
    end

    // Zero-wait fill from IDLE; done must then hold.
    run_fill(90);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("done_hold", 64'(done), 64'd1);
      chk("busy_hold", 64'(busy), 64'd0);
    end

    // waitrequest high for 5 cycles on row 3.
    wait_addr = 3;
    wait_left = 5;
    run_fill(95);
    wait_left = 0;

    // FIFO 8 full for 4 cycles after byte 2, other FIFOs full meanwhile,
    // stray readdatavalid pulses outside WAIT.
    full_mode = 1'b1;
    full_left = 4;
    junk      = 1'b1;
    run_fill(94);
    full_mode = 1'b0;
    junk      = 1'b0;

    // start during row 2 is ignored; a start in DONE restarts from row 0.
    restart_row = 2;
    run_fill(90);
    restart_row = -1;
    run_fill(90);

    // Reset in WAIT of row 5 while its response arrives.
    abort_row = 5;
    run_fill(0);
    chk("abort_reached", 64'(aborted), 64'd1);
    abort_row = -1;
    repeat (2) cyc();
    rst_n = 1'b1;
    junk  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_read", 64'(mem_read), 64'd0);
    end
    junk = 1'b0;
    cyc();
    run_fill(90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
